// File: rtl/spi_command_decoder.sv
// SPI mode-0 peripheral: deserialises host bytes into an opcode plus a stream of operand bytes,
// and returns a chip ID byte on MISO after the read-ID opcode.
module spi_command_decoder #(
    parameter logic [7:0] READ_ID_OPCODE = 8'hDB,
    parameter logic [7:0] CHIP_ID        = 8'h81
) (
    input  logic        clock_in,
    input  logic        reset_n_in,
    input  logic        spi_sck_in,
    input  logic        spi_cs_n_in,
    input  logic        spi_mosi_in,
    output logic        spi_miso_out,
    output logic [7:0]  op_code_out,
    output logic        op_code_valid_out,
    output logic [7:0]  operand_out,
    output logic        operand_valid_out,
    output logic [31:0] operand_count_out
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t      state, state_next;
    logic [2:0]  sck_sync;   // [0]=s1, [1]=s2, [2]=edge-detect delay
    logic [2:0]  cs_sync;
    logic [1:0]  mosi_sync;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic [7:0]  miso_sr;
    logic        miso_loaded;

    logic sck_rise, sck_fall, cs_rise, cs_fall;
    logic start, stop, shift_en, miso_en;
    logic [7:0] byte_next;

    assign sck_rise  = sck_sync[1] & ~sck_sync[2];
    assign sck_fall  = ~sck_sync[1] & sck_sync[2];
    assign cs_rise   = cs_sync[1] & ~cs_sync[2];
    assign cs_fall   = ~cs_sync[1] & cs_sync[2];
    assign byte_next = {shift_reg[6:0], mosi_sync[1]};

    assign spi_miso_out = miso_sr[7];

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            sck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
        end else begin
            sck_sync  <= {sck_sync[1:0], spi_sck_in};
            cs_sync   <= {cs_sync[1:0], spi_cs_n_in};
            mosi_sync <= {mosi_sync[0], spi_mosi_in};
        end
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) state <= IDLE;
        else             state <= state_next;
    end

    // A CS fall is only seen after CS was synchronised high, so a transaction already
    // in progress when reset releases is never picked up mid-way.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        stop       = 1'b0;
        shift_en   = 1'b0;
        miso_en    = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next = ACTIVE;
                    start      = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    stop       = 1'b1;
                end else begin
                    shift_en = sck_rise;
                    miso_en  = sck_fall & op_code_valid_out;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            bit_cnt           <= '0;
            shift_reg         <= '0;
            miso_sr           <= '0;
            miso_loaded       <= 1'b0;
            op_code_out       <= '0;
            op_code_valid_out <= 1'b0;
            operand_out       <= '0;
            operand_valid_out <= 1'b0;
            operand_count_out <= '0;
        end else begin
            operand_valid_out <= 1'b0;
            if (start || stop) begin
                bit_cnt     <= '0;
                shift_reg   <= '0;
                miso_sr     <= '0;
                miso_loaded <= 1'b0;
            end
            if (stop) begin
                op_code_valid_out <= 1'b0;
                operand_count_out <= '0;
            end
            if (shift_en) begin
                shift_reg <= byte_next;
                bit_cnt   <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    if (!op_code_valid_out) begin
                        op_code_out       <= byte_next;
                        op_code_valid_out <= 1'b1;
                    end else begin
                        operand_out       <= byte_next;
                        operand_valid_out <= 1'b1;
                        if (operand_count_out != 32'hFFFF_FFFF)
                            operand_count_out <= operand_count_out + 32'd1;
                    end
                end
            end
            // First fall after the opcode loads the reply; later falls shift zeros in.
            if (miso_en) begin
                if (!miso_loaded) begin
                    miso_sr     <= (op_code_out == READ_ID_OPCODE) ? CHIP_ID : 8'h00;
                    miso_loaded <= 1'b1;
                end else begin
                    miso_sr <= {miso_sr[6:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_command_decoder.sv
// Randomised bench for spi_command_decoder: a byte-level host model drives SPI transactions and
// compares the decoded opcode/operand stream and MISO bytes against expectations built from the byte lists.
module tb_spi_command_decoder;

    localparam int HALF = 8;  // SCK half-period in clock_in cycles

    typedef logic [7:0] byteq_t[$];
    typedef struct packed {
        logic [7:0]  data;
        logic [31:0] cnt;
    } pulse_t;

    logic        clock_in = 1'b0;
    logic        reset_n_in = 1'b0;
    logic        spi_sck_in = 1'b0;
    logic        spi_cs_n_in = 1'b1;
    logic        spi_mosi_in = 1'b0;
    logic        spi_miso_out;
    logic [7:0]  op_code_out;
    logic        op_code_valid_out;
    logic [7:0]  operand_out;
    logic        operand_valid_out;
    logic [31:0] operand_count_out;

    int          n_chk = 0;
    int          n_fail = 0;
    pulse_t      pulses[$];
    logic [7:0]  last_operand = 8'h00;

    spi_command_decoder dut (
        .clock_in          (clock_in),
        .reset_n_in        (reset_n_in),
        .spi_sck_in        (spi_sck_in),
        .spi_cs_n_in       (spi_cs_n_in),
        .spi_mosi_in       (spi_mosi_in),
        .spi_miso_out      (spi_miso_out),
        .op_code_out       (op_code_out),
        .op_code_valid_out (op_code_valid_out),
        .operand_out       (operand_out),
        .operand_valid_out (operand_valid_out),
        .operand_count_out (operand_count_out)
    );

    always #5 clock_in = ~clock_in;

    // Every high sample of the valid strobe is one pulse; a stretched pulse shows up as an extra entry.
    always @(negedge clock_in)
        if (operand_valid_out === 1'b1)
            pulses.push_back(pulse_t'{operand_out, operand_count_out});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock_in);
    endtask

    // Host side of mode 0: data set while SCK low, MISO sampled at the rising edge.
    task automatic send_bits(input logic [7:0] b, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi_in = b[7-i];
            cyc(HALF);
            rx = {rx[6:0], spi_miso_out};
            spi_sck_in = 1'b1;
            cyc(HALF);
            spi_sck_in = 1'b0;
        end
    endtask

    task automatic run_txn(input string name, input byteq_t bytes, input int partial, input logic [7:0] pbyte);
        logic [7:0] rx;
        logic [7:0] exp_rx;
        int         nops;
        int         nchk;
        nops = bytes.size() - 1;
        pulses.delete();
        spi_cs_n_in = 1'b0;
        cyc(HALF);
        for (int i = 0; i < bytes.size(); i++) begin
            send_bits(bytes[i], 8, rx);
            if (i == 0) begin
                cyc(3);
                check({name, "/opcode"}, {24'h0, op_code_out}, {24'h0, bytes[0]});
                check({name, "/op_valid_set"}, {31'h0, op_code_valid_out}, 32'd1);
            end
            exp_rx = (i == 1 && bytes[0] == 8'hDB) ? 8'h81 : 8'h00;
            check({name, $sformatf("/miso_byte%0d", i)}, {24'h0, rx}, {24'h0, exp_rx});
        end
        if (partial > 0) send_bits(pbyte, partial, rx);
        cyc(HALF);
        check({name, "/op_valid_hold"}, {31'h0, op_code_valid_out}, 32'd1);
        check({name, "/count_live"}, operand_count_out, nops);
        spi_cs_n_in = 1'b1;
        cyc(3);
        check({name, "/op_valid_clr"}, {31'h0, op_code_valid_out}, 32'd0);
        check({name, "/count_clr"}, operand_count_out, 32'd0);
        check({name, "/miso_idle"}, {31'h0, spi_miso_out}, 32'd0);
        cyc(HALF);
        check({name, "/n_pulses"}, pulses.size(), nops);
        nchk = (pulses.size() < nops) ? pulses.size() : nops;
        for (int k = 0; k < nchk; k++) begin
            check({name, $sformatf("/operand%0d", k + 1)}, {24'h0, pulses[k].data}, {24'h0, bytes[k+1]});
            check({name, $sformatf("/count%0d", k + 1)}, pulses[k].cnt, k + 1);
        end
        if (nops > 0) last_operand = bytes[nops];
        check({name, "/opcode_hold"}, {24'h0, op_code_out}, {24'h0, bytes[0]});
        check({name, "/operand_hold"}, {24'h0, operand_out}, {24'h0, last_operand});
    endtask

    initial begin
        logic [7:0] rx;
        byteq_t     q;
        int         nops;

        cyc(3);
        check("rst/miso", {31'h0, spi_miso_out}, 32'd0);
        check("rst/opcode", {24'h0, op_code_out}, 32'd0);
        check("rst/op_valid", {31'h0, op_code_valid_out}, 32'd0);
        check("rst/operand", {24'h0, operand_out}, 32'd0);
        check("rst/operand_valid", {31'h0, operand_valid_out}, 32'd0);
        check("rst/count", operand_count_out, 32'd0);
        reset_n_in = 1'b1;
        cyc(4);

        q = '{8'h11, 8'h05, 8'hA0, 8'hC0, 8'hE0};
        run_txn("color", q, 0, 8'h00);
        q = '{8'h10};
        run_txn("oponly", q, 0, 8'h00);
        q = '{8'hDB, 8'h00, 8'h00};
        run_txn("readid", q, 0, 8'h00);
        q = '{8'h12, 8'h03};
        run_txn("partial", q, 5, 8'hFF);
        q = '{8'h14};
        run_txn("after_partial", q, 0, 8'h00);

        // Reset in the middle of an operand; the rest of that transaction must be ignored.
        pulses.delete();
        spi_cs_n_in = 1'b0;
        cyc(HALF);
        send_bits(8'h12, 8, rx);
        send_bits(8'hA5, 3, rx);
        reset_n_in = 1'b0;
        cyc(2);
        check("midrst/opcode", {24'h0, op_code_out}, 32'd0);
        check("midrst/operand", {24'h0, operand_out}, 32'd0);
        check("midrst/op_valid", {31'h0, op_code_valid_out}, 32'd0);
        reset_n_in = 1'b1;
        last_operand = 8'h00;
        send_bits(8'hFF, 5, rx);
        send_bits(8'h5A, 8, rx);
        check("midrst/miso", {24'h0, rx}, 32'd0);
        send_bits(8'h3C, 8, rx);
        check("midrst/op_valid_after", {31'h0, op_code_valid_out}, 32'd0);
        check("midrst/opcode_after", {24'h0, op_code_out}, 32'd0);
        check("midrst/count_after", operand_count_out, 32'd0);
        check("midrst/n_pulses", pulses.size(), 32'd0);
        spi_cs_n_in = 1'b1;
        cyc(HALF);
        q = '{8'h10};
        run_txn("post_rst", q, 0, 8'h00);

        // CS rise lands on the same synchronised cycle as the completing SCK rise.
        q = '{8'h20, 8'h44};
        run_txn("pre_coll", q, 0, 8'h00);
        pulses.delete();
        spi_cs_n_in = 1'b0;
        cyc(HALF);
        send_bits(8'h20, 8, rx);
        send_bits(8'h77, 7, rx);
        spi_mosi_in = 1'b1;
        cyc(HALF);
        spi_sck_in  = 1'b1;
        spi_cs_n_in = 1'b1;
        cyc(3);
        check("coll/op_valid", {31'h0, op_code_valid_out}, 32'd0);
        cyc(HALF);
        spi_sck_in = 1'b0;
        cyc(HALF);
        check("coll/n_pulses", pulses.size(), 32'd0);
        check("coll/count", operand_count_out, 32'd0);
        check("coll/operand_hold", {24'h0, operand_out}, {24'h0, last_operand});

        for (int t = 0; t < 20; t++) begin
            q.delete();
            q.push_back(($urandom_range(0, 3) == 0) ? 8'hDB : 8'($urandom));
            nops = $urandom_range(0, 4);
            for (int k = 0; k < nops; k++) q.push_back(8'($urandom));
            run_txn($sformatf("rnd%0d", t), q,
                    ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 7)), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
